// File: rtl/shift_seq_detector_if.sv
// Serial-bit interface for the 1101 detector: the sampled bit stream in,
// the shift register contents and the match status out.
interface shift_seq_detector_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             en;
  logic             din;
  logic [WIDTH-1:0] q;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (output en, output din,
                  input q, input match, input match_cnt, input cnt_sat);
  modport slave  (input en, input din,
                  output q, output match, output match_cnt, output cnt_sat);
endinterface

// File: rtl/shift_seq_detector.sv
// Serial-in/parallel-out shift register with an overlapping 1101 Moore detector
// and a saturating match counter.
module shift_seq_detector #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  shift_seq_detector_if.slave bus
);

  typedef enum logic [2:0] {S0, S1, S2, S3, S4} state_t;

  logic [WIDTH-1:0] q_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             match_p0;
  state_t           state_p0;

  function automatic state_t next_state(input state_t s, input logic d);
    case (s)
      S0:      return d ? S1 : S0;
      S1:      return d ? S2 : S0;
      S2:      return d ? S2 : S3;
      S3:      return d ? S4 : S0;
      // Trailing "1" of the match plus the new "1" already forms "11".
      S4:      return d ? S2 : S0;
      default: return S0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Stage p0: shift, state advance and counting, all gated by the sample strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      q_p0     <= '0;
      state_p0 <= S0;
      match_p0 <= 1'b0;
      cnt_p0   <= '0;
    end else if (bus.en) begin
      q_p0     <= {q_p0[WIDTH-2:0], bus.din};
      state_p0 <= next_state(state_p0, bus.din);
      match_p0 <= (next_state(state_p0, bus.din) == S4);
      if (state_p0 == S3 && bus.din)
        cnt_p0 <= sat_inc(cnt_p0);
    end
  end

  assign bus.q         = q_p0;
  assign bus.match     = match_p0;
  assign bus.match_cnt = cnt_p0;
  assign bus.cnt_sat   = (cnt_p0 == {CNT_W{1'b1}});

endmodule

// File: tb/tb_shift_seq_detector.sv
// Randomised and directed bench for shift_seq_detector against a bit-history model.
module tb_shift_seq_detector;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shift_seq_detector_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_seq_detector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: every bit accepted since the last reset, and number of 1101 endings seen.
  bit hist[$];
  int n_match = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit ends_1101();
    int sz = hist.size();
    if (sz < 4) return 1'b0;
    return hist[sz-4] && hist[sz-3] && !hist[sz-2] && hist[sz-1];
  endfunction

  function automatic logic [WIDTH-1:0] exp_q();
    logic [WIDTH-1:0] v = '0;
    int sz = hist.size();
    for (int i = 0; i < WIDTH; i++)
      if (i < sz) v[i] = hist[sz-1-i];
    return v;
  endfunction

  task automatic compare_all(input string tag);
    int c = (n_match > CMAX) ? CMAX : n_match;
    check({tag, "_q"},     32'(bus.q),         32'(exp_q()));
    check({tag, "_match"}, 32'(bus.match),     32'(ends_1101()));
    check({tag, "_cnt"},   32'(bus.match_cnt), 32'(c));
    check({tag, "_sat"},   32'(bus.cnt_sat),   32'(c == CMAX));
  endtask

  // One clock: drive, clock, update model, compare everything.
  task automatic step(input logic r, input logic e, input logic d, input string tag);
    rst = r; bus.en = e; bus.din = d;
    @(posedge clk);
    #1;
    if (r) begin
      hist.delete();
      n_match = 0;
    end else if (e) begin
      hist.push_back(d);
      if (ends_1101()) n_match++;
    end
    compare_all(tag);
  endtask

  task automatic send(input logic [31:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], tag);
  endtask

  initial begin
    bus.en = 1'b0; bus.din = 1'b0;
    #2;
    // Test 1: reset for two clocks
    step(1'b1, 1'b1, 1'b1, "t1");
    step(1'b1, 1'b1, 1'b1, "t1");
    check("t1_q_const", 32'(bus.q), 32'h00);

    // Test 2: single 1101
    send(32'b1101, 4, "t2");
    check("t2_q_const", 32'(bus.q), 32'h0D);
    check("t2_match_const", 32'(bus.match), 32'd1);
    check("t2_cnt_const", 32'(bus.match_cnt), 32'd1);

    // Test 3: overlapping 1101101
    step(1'b1, 1'b0, 1'b0, "t3r");
    send(32'b1101101, 7, "t3");
    check("t3_q_const", 32'(bus.q), 32'h6D);
    check("t3_cnt_const", 32'(bus.match_cnt), 32'd2);

    // Test 4: en gaps mid-pattern and after the match
    step(1'b1, 1'b0, 1'b0, "t4r");
    send(32'b11, 2, "t4");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, "t4hold");
    send(32'b01, 2, "t4");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, i[0], "t4mhold");
    check("t4_match_const", 32'(bus.match), 32'd1);
    check("t4_cnt_const", 32'(bus.match_cnt), 32'd1);

    // Test 5: saturate the counter
    step(1'b1, 1'b0, 1'b0, "t5r");
    send(32'b1101, 4, "t5");
    for (int i = 0; i < 15; i++) send(32'b101, 3, "t5");
    check("t5_cnt_const", 32'(bus.match_cnt), 32'd15);
    check("t5_sat_const", 32'(bus.cnt_sat), 32'd1);
    for (int i = 0; i < 3; i++) send(32'b101, 3, "t5post");

    // Test 6: reset discards a partial prefix
    step(1'b1, 1'b0, 1'b0, "t6r");
    send(32'b110, 3, "t6");
    step(1'b1, 1'b1, 1'b1, "t6r2");
    send(32'b1, 1, "t6");
    check("t6_q_const", 32'(bus.q), 32'h01);
    check("t6_cnt_const", 32'(bus.match_cnt), 32'd0);
    send(32'b101, 3, "t6tail");

    // Random: pattern-biased bits, occasional en gaps and rare resets
    for (int i = 0; i < 600; i++) begin
      logic r = ($urandom_range(0, 79) == 0);
      logic e = ($urandom_range(0, 3) != 0);
      logic d = ($urandom_range(0, 2) != 0);
      step(r, e, d, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
